// File: rtl/ex_pkg.sv
// ============================================================================
// ex_pkg : shared encodings for the execute stage (ALU ops, flag bits, mul FSM)
// Revision: 1.0
// ============================================================================
`default_nettype none

package ex_pkg;

  localparam logic [2:0] ALUOP_ADD = 3'b000;
  localparam logic [2:0] ALUOP_SUB = 3'b001;
  localparam logic [2:0] ALUOP_AND = 3'b010;
  localparam logic [2:0] ALUOP_OR  = 3'b011;
  localparam logic [2:0] ALUOP_XOR = 3'b100;
  localparam logic [2:0] ALUOP_SHL = 3'b101;
  localparam logic [2:0] ALUOP_SHR = 3'b110;
  localparam logic [2:0] ALUOP_MUL = 3'b111;

  // Flag register layout is {Z,N,C,V}
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int MUL_ITER = 16;

  localparam logic [1:0] MUL_IDLE = 2'd0;
  localparam logic [1:0] MUL_BUSY = 2'd1;
  localparam logic [1:0] MUL_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/ex_mul_seq.sv
// ============================================================================
// ex_mul_seq : iterative shift-add multiplier, one bit per cycle; used only
//              when EX_MULDIV_EN is defined. Revision: 1.0
// ============================================================================
`default_nettype none

module ex_mul_seq
  import ex_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              kill_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  logic [1:0]        state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] acc_q, acc_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    if (kill_i) begin
      // A kill abandons the partial product outright
      state_d = MUL_IDLE;
      cnt_d   = 5'd0;
      acc_d   = '0;
    end else begin
      case (state_q)
        MUL_IDLE: begin
          if (start_i) begin
            state_d = MUL_BUSY;
            a_d     = a_i;
            b_d     = b_i;
            acc_d   = '0;
            cnt_d   = 5'd0;
          end
        end
        MUL_BUSY: begin
          if (b_q[0]) acc_d = acc_q + a_q;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(MUL_ITER - 1)) state_d = MUL_DONE;
        end
        MUL_DONE: state_d = MUL_IDLE;
        default:  state_d = MUL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MUL_IDLE;
      cnt_q   <= 5'd0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  assign busy_o    = (state_q == MUL_BUSY);
  assign done_o    = (state_q == MUL_DONE);
  assign product_o = acc_q;

endmodule

`default_nettype wire

// File: rtl/ex_stage.sv
// ============================================================================
// ex_stage : execute stage - forwarding, ALU, flag register, optional
//            iterative multiplier enabled by EX_MULDIV_EN. Revision: 1.0
// ============================================================================
`default_nettype none

module ex_stage
  import ex_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       pc_i,
  input  logic [DATA_W-1:0] rdata1_i,
  input  logic [DATA_W-1:0] rdata2_i,
  input  logic [3:0]        raddr1_i,
  input  logic [3:0]        raddr2_i,
  input  logic [3:0]        waddr_i,
  input  logic [3:0]        imm_i,
  input  logic [7:0]        immed_i,
  input  logic [2:0]        aluop_i,
  input  logic              bsc_i,
  input  logic              immedsc_i,
  input  logic              modify_i,
  input  logic              dmwen_i,
  input  logic              rfwen_i,
  input  logic              exe_i,
  input  logic [1:0]        wdatasc1_i,
  input  logic              wdatasc2_i,
  input  logic              postflush_i,
  input  logic              poststall_i,
  input  logic              exmem_rfwen_i,
  input  logic [3:0]        exmem_waddr_i,
  input  logic [DATA_W-1:0] exmem_data_i,
  input  logic              memwb_rfwen_i,
  input  logic [3:0]        memwb_waddr_i,
  input  logic [DATA_W-1:0] memwb_data_i,
  input  logic              ex_kill_i,
  output logic [DATA_W-1:0] result_o,
  output logic [DATA_W-1:0] store_data_o,
  output logic [3:0]        waddr_o,
  output logic [15:0]       pc_o,
  output logic [1:0]        wdatasc1_o,
  output logic              wdatasc2_o,
  output logic              rfwen_o,
  output logic              dmwen_o,
  output logic [3:0]        flags_o,
  output logic              ex_stall_o
);

  logic              valid;
  logic              ex_stall;
  logic [DATA_W-1:0] fwd_a, fwd_b, imm_ext, op_b, alu_res;
  logic [DATA_W:0]   add_ext, sub_ext;
  logic              flag_c, flag_v;
  logic [3:0]        flags_q, flags_d;

  assign valid = exe_i & ~postflush_i & ~poststall_i & ~ex_kill_i;

  // EX/MEM is the younger producer, so it wins over MEM/WB
  always_comb begin
    fwd_a = rdata1_i;
    if (exmem_rfwen_i && (exmem_waddr_i == raddr1_i))      fwd_a = exmem_data_i;
    else if (memwb_rfwen_i && (memwb_waddr_i == raddr1_i)) fwd_a = memwb_data_i;
  end

  always_comb begin
    fwd_b = rdata2_i;
    if (exmem_rfwen_i && (exmem_waddr_i == raddr2_i))      fwd_b = exmem_data_i;
    else if (memwb_rfwen_i && (memwb_waddr_i == raddr2_i)) fwd_b = memwb_data_i;
  end

  assign imm_ext = immedsc_i ? {{(DATA_W-8){immed_i[7]}}, immed_i}
                             : {{(DATA_W-4){1'b0}}, imm_i};
  assign op_b    = bsc_i ? imm_ext : fwd_b;
  assign add_ext = {1'b0, fwd_a} + {1'b0, op_b};
  assign sub_ext = {1'b0, fwd_a} - {1'b0, op_b};

`ifdef EX_MULDIV_EN
  logic              mul_start, mul_busy, mul_done;
  logic [DATA_W-1:0] mul_product;

  // Start only from IDLE so the DONE cycle never relaunches the same MUL
  assign mul_start = valid & (aluop_i == ALUOP_MUL) & ~mul_busy & ~mul_done;

  ex_mul_seq #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mul_start),
    .kill_i    (ex_kill_i),
    .a_i       (fwd_a),
    .b_i       (op_b),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  assign ex_stall = mul_start | mul_busy;
`else
  assign ex_stall = 1'b0;
`endif

  always_comb begin
    alu_res = '0;
    flag_c  = 1'b0;
    flag_v  = 1'b0;
    case (aluop_i)
      ALUOP_ADD: begin
        alu_res = add_ext[DATA_W-1:0];
        flag_c  = add_ext[DATA_W];
        flag_v  = (fwd_a[DATA_W-1] == op_b[DATA_W-1]) &&
                  (add_ext[DATA_W-1] != fwd_a[DATA_W-1]);
      end
      ALUOP_SUB: begin
        alu_res = sub_ext[DATA_W-1:0];
        flag_c  = sub_ext[DATA_W];
        flag_v  = (fwd_a[DATA_W-1] != op_b[DATA_W-1]) &&
                  (sub_ext[DATA_W-1] != fwd_a[DATA_W-1]);
      end
      ALUOP_AND: alu_res = fwd_a & op_b;
      ALUOP_OR:  alu_res = fwd_a | op_b;
      ALUOP_XOR: alu_res = fwd_a ^ op_b;
      ALUOP_SHL: alu_res = fwd_a << imm_i;
      ALUOP_SHR: alu_res = fwd_a >> imm_i;
`ifdef EX_MULDIV_EN
      ALUOP_MUL: alu_res = mul_done ? mul_product : '0;
`else
      ALUOP_MUL: alu_res = '0;
`endif
      default:   alu_res = '0;
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    if (valid && modify_i && !ex_stall) begin
      flags_d[FLAG_Z] = (alu_res == '0);
      flags_d[FLAG_N] = alu_res[DATA_W-1];
      flags_d[FLAG_C] = flag_c;
      flags_d[FLAG_V] = flag_v;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) flags_q <= 4'b0000;
    else     flags_q <= flags_d;
  end

  assign result_o     = alu_res;
  assign store_data_o = fwd_b;
  assign waddr_o      = waddr_i;
  assign pc_o         = pc_i;
  assign wdatasc1_o   = wdatasc1_i;
  assign wdatasc2_o   = wdatasc2_i;
  assign rfwen_o      = rfwen_i & valid & ~ex_stall;
  assign dmwen_o      = dmwen_i & valid & ~ex_stall;
  assign flags_o      = flags_q;
  assign ex_stall_o   = ex_stall;

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
// ============================================================================
// tb_ex_stage : self-checking bench for ex_stage (both EX_MULDIV_EN builds)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ex_stage;

`ifdef EX_MULDIV_EN
  localparam int MAXOP = 6;
`else
  localparam int MAXOP = 7;
`endif

  logic        clk, rst;
  logic [15:0] pc_i, rdata1_i, rdata2_i;
  logic [3:0]  raddr1_i, raddr2_i, waddr_i, imm_i;
  logic [7:0]  immed_i;
  logic [2:0]  aluop_i;
  logic        bsc_i, immedsc_i, modify_i, dmwen_i, rfwen_i, exe_i;
  logic [1:0]  wdatasc1_i;
  logic        wdatasc2_i, postflush_i, poststall_i;
  logic        exmem_rfwen_i, memwb_rfwen_i, ex_kill_i;
  logic [3:0]  exmem_waddr_i, memwb_waddr_i;
  logic [15:0] exmem_data_i, memwb_data_i;
  logic [15:0] result_o, store_data_o, pc_o;
  logic [3:0]  waddr_o, flags_o;
  logic [1:0]  wdatasc1_o;
  logic        wdatasc2_o, rfwen_o, dmwen_o, ex_stall_o;

  int          n_vec;
  int          n_err;
  logic [3:0]  exp_flags;

  ex_stage #(.DATA_W(16)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .rdata1_i(rdata1_i), .rdata2_i(rdata2_i),
    .raddr1_i(raddr1_i), .raddr2_i(raddr2_i), .waddr_i(waddr_i), .imm_i(imm_i),
    .immed_i(immed_i), .aluop_i(aluop_i), .bsc_i(bsc_i), .immedsc_i(immedsc_i),
    .modify_i(modify_i), .dmwen_i(dmwen_i), .rfwen_i(rfwen_i), .exe_i(exe_i),
    .wdatasc1_i(wdatasc1_i), .wdatasc2_i(wdatasc2_i), .postflush_i(postflush_i),
    .poststall_i(poststall_i), .exmem_rfwen_i(exmem_rfwen_i),
    .exmem_waddr_i(exmem_waddr_i), .exmem_data_i(exmem_data_i),
    .memwb_rfwen_i(memwb_rfwen_i), .memwb_waddr_i(memwb_waddr_i),
    .memwb_data_i(memwb_data_i), .ex_kill_i(ex_kill_i), .result_o(result_o),
    .store_data_o(store_data_o), .waddr_o(waddr_o), .pc_o(pc_o),
    .wdatasc1_o(wdatasc1_o), .wdatasc2_o(wdatasc2_o), .rfwen_o(rfwen_o),
    .dmwen_o(dmwen_o), .flags_o(flags_o), .ex_stall_o(ex_stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: returns {Z,N,C,V,result} from integer arithmetic
  function automatic logic [19:0] ref_exec(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [3:0] sh);
    longint ua, ub, r;
    int     sa, sb;
    logic   c, v;
    logic [15:0] res;
    ua = longint'(a);
    ub = longint'(b);
    sa = int'(a) - (a[15] ? 65536 : 0);
    sb = int'(b) - (b[15] ? 65536 : 0);
    c  = 1'b0;
    v  = 1'b0;
    r  = 0;
    case (op)
      3'd0: begin r = ua + ub; c = (r > 65535); v = (sa + sb > 32767) || (sa + sb < -32768); end
      3'd1: begin r = ua - ub; c = (ua < ub);  v = (sa - sb > 32767) || (sa - sb < -32768); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = ua << sh;
      3'd6: r = ua >> sh;
`ifdef EX_MULDIV_EN
      default: r = ua * ub;
`else
      default: r = 0;
`endif
    endcase
    res = r[15:0];
    return {(res == 16'h0000), res[15], c, v, res};
  endfunction

  function automatic logic [15:0] model_fwd(input logic [3:0] ra, input logic [15:0] rd);
    if (exmem_rfwen_i && exmem_waddr_i == ra) return exmem_data_i;
    if (memwb_rfwen_i && memwb_waddr_i == ra) return memwb_data_i;
    return rd;
  endfunction

  function automatic logic [15:0] model_opb();
    int iv;
    if (!bsc_i) return model_fwd(raddr2_i, rdata2_i);
    iv = immedsc_i ? (int'(immed_i) - (immed_i[7] ? 256 : 0)) : int'(imm_i);
    return 16'(iv);
  endfunction

  task automatic clear_inputs();
    pc_i = 0; rdata1_i = 0; rdata2_i = 0; raddr1_i = 0; raddr2_i = 0; waddr_i = 0;
    imm_i = 0; immed_i = 0; aluop_i = 0; bsc_i = 0; immedsc_i = 0; modify_i = 0;
    dmwen_i = 0; rfwen_i = 0; exe_i = 0; wdatasc1_i = 0; wdatasc2_i = 0;
    postflush_i = 0; poststall_i = 0; exmem_rfwen_i = 0; exmem_waddr_i = 0;
    exmem_data_i = 0; memwb_rfwen_i = 0; memwb_waddr_i = 0; memwb_data_i = 0;
    ex_kill_i = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    n_vec++; if (flags_o !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b expected 0000", flags_o); end
    n_vec++; if (ex_stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b expected 0", ex_stall_o); end
    n_vec++; if (result_o !== 16'h0000 || pc_o !== 16'h0000 || rfwen_o !== 1'b0) begin
      n_err++; $display("FAIL reset_outputs: got result %h pc %h rfwen %b expected 0", result_o, pc_o, rfwen_o); end
    rst = 1'b0;
    exp_flags = 4'b0000;
  endtask

  task automatic test_add_overflow();
    clear_inputs();
    rdata1_i = 16'h7FFF; rdata2_i = 16'h0001; raddr1_i = 1; raddr2_i = 2;
    aluop_i = 3'd0; exe_i = 1; rfwen_i = 1; modify_i = 1;
    #2;
    n_vec++; if (result_o !== 16'h8000 || rfwen_o !== 1'b1) begin
      n_err++; $display("FAIL add_ovf_result: got %h/%b expected 8000/1", result_o, rfwen_o); end
    @(posedge clk); #1;
    exp_flags = 4'b0101;
    n_vec++; if (flags_o !== exp_flags) begin n_err++; $display("FAIL add_ovf_flags: got %b expected %b", flags_o, exp_flags); end
    clear_inputs();
  endtask

  task automatic test_sub();
    clear_inputs();
    rdata1_i = 16'h0003; rdata2_i = 16'h0005; raddr1_i = 1; raddr2_i = 2;
    aluop_i = 3'd1; exe_i = 1; modify_i = 1;
    #2;
    n_vec++; if (result_o !== 16'hFFFE) begin n_err++; $display("FAIL sub_result: got %h expected fffe", result_o); end
    @(posedge clk); #1;
    exp_flags = 4'b0110;
    n_vec++; if (flags_o !== exp_flags) begin n_err++; $display("FAIL sub_flags: got %b expected %b", flags_o, exp_flags); end
    clear_inputs();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    raddr1_i = 0; raddr2_i = 0; rdata1_i = 16'hAAAA; rdata2_i = 16'hBBBB;
    exmem_rfwen_i = 1; exmem_waddr_i = 0; exmem_data_i = 16'h1111;
    memwb_rfwen_i = 1; memwb_waddr_i = 0; memwb_data_i = 16'h2222;
    bsc_i = 1; immedsc_i = 0; imm_i = 0; aluop_i = 3'd3; exe_i = 1;
    #2;
    n_vec++; if (result_o !== 16'h1111 || store_data_o !== 16'h1111) begin
      n_err++; $display("FAIL fwd_exmem: got %h/%h expected 1111/1111", result_o, store_data_o); end
    exmem_rfwen_i = 0;
    #2;
    n_vec++; if (result_o !== 16'h2222 || store_data_o !== 16'h2222) begin
      n_err++; $display("FAIL fwd_memwb: got %h/%h expected 2222/2222", result_o, store_data_o); end
    memwb_waddr_i = 5; exmem_rfwen_i = 1; exmem_waddr_i = 7;
    #2;
    n_vec++; if (result_o !== 16'hAAAA || store_data_o !== 16'hBBBB) begin
      n_err++; $display("FAIL fwd_none: got %h/%h expected aaaa/bbbb", result_o, store_data_o); end
    @(posedge clk); #1;
    n_vec++; if (flags_o !== exp_flags) begin n_err++; $display("FAIL fwd_flags_kept: got %b expected %b", flags_o, exp_flags); end
    clear_inputs();
  endtask

  task automatic test_immediate();
    clear_inputs();
    rdata1_i = 16'h0010; rdata2_i = 16'h1234; raddr1_i = 1; raddr2_i = 2;
    bsc_i = 1; immedsc_i = 1; immed_i = 8'hF0; aluop_i = 3'd0; exe_i = 1; modify_i = 1;
    #2;
    n_vec++; if (result_o !== 16'h0000 || store_data_o !== 16'h1234) begin
      n_err++; $display("FAIL imm_sext: got %h/%h expected 0000/1234", result_o, store_data_o); end
    @(posedge clk); #1;
    exp_flags = 4'b1010;
    n_vec++; if (flags_o !== exp_flags) begin n_err++; $display("FAIL imm_flags: got %b expected %b", flags_o, exp_flags); end
    immedsc_i = 0; imm_i = 4'hF; modify_i = 0;
    #2;
    n_vec++; if (result_o !== 16'h001F) begin n_err++; $display("FAIL imm_zext: got %h expected 001f", result_o); end
    @(posedge clk); #1;
    clear_inputs();
  endtask

`ifdef EX_MULDIV_EN
  task automatic test_mul_seq(input logic [15:0] a, input logic [15:0] b);
    logic [19:0] exp;
    int          stalls;
    exp    = ref_exec(3'd7, a, b, 4'd0);
    stalls = 0;
    clear_inputs();
    rdata1_i = a; rdata2_i = b; raddr1_i = 1; raddr2_i = 2;
    aluop_i = 3'd7; exe_i = 1; rfwen_i = 1; modify_i = 1;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (ex_stall_o === 1'b1) stalls++;
      n_vec++; if (ex_stall_o !== (k <= 16)) begin
        n_err++; $display("FAIL mul_stall cycle %0d: got %b expected %b", k, ex_stall_o, (k <= 16)); end
      if (k == 17) begin
        n_vec++; if (result_o !== exp[15:0] || rfwen_o !== 1'b1) begin
          n_err++; $display("FAIL mul_result: got %h/%b expected %h/1", result_o, rfwen_o, exp[15:0]); end
      end else begin
        n_vec++; if (rfwen_o !== 1'b0 || flags_o !== exp_flags) begin
          n_err++; $display("FAIL mul_busy cycle %0d: got rfwen %b flags %b expected 0/%b", k, rfwen_o, flags_o, exp_flags); end
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    exe_i = 0;
    exp_flags = exp[19:16];
    n_vec++; if (stalls != 17) begin n_err++; $display("FAIL mul_stall_count: got %0d expected 17", stalls); end
    n_vec++; if (flags_o !== exp_flags) begin n_err++; $display("FAIL mul_flags: got %b expected %b", flags_o, exp_flags); end
    clear_inputs();
  endtask

  task automatic test_mul_abort(input bit use_rst);
    clear_inputs();
    rdata1_i = 16'h7FFF; rdata2_i = 16'h0001; raddr1_i = 1; raddr2_i = 2;
    aluop_i = 3'd0; exe_i = 1; modify_i = 1;
    @(posedge clk); #1;
    exp_flags = 4'b0101;
    rdata1_i = 16'h0012; rdata2_i = 16'h0034; aluop_i = 3'd7; rfwen_i = 1;
    for (int k = 0; k < 21; k++) begin
      if (k == 5) begin
        if (use_rst) rst = 1'b1; else ex_kill_i = 1'b1;
      end
      if (k == 6) begin rst = 1'b0; ex_kill_i = 1'b0; exe_i = 1'b0; end
      @(negedge clk);
      n_vec++; if (ex_stall_o !== (k <= 5) || rfwen_o !== 1'b0) begin
        n_err++; $display("FAIL abort%0d cycle %0d: got stall %b rfwen %b expected %b/0", use_rst, k, ex_stall_o, rfwen_o, (k <= 5)); end
      @(posedge clk); #1;
    end
    if (use_rst) exp_flags = 4'b0000;
    n_vec++; if (flags_o !== exp_flags) begin n_err++; $display("FAIL abort%0d_flags: got %b expected %b", use_rst, flags_o, exp_flags); end
    clear_inputs();
  endtask
`else
  task automatic test_mul_single();
    clear_inputs();
    rdata1_i = 16'h0012; rdata2_i = 16'h0034; raddr1_i = 1; raddr2_i = 2;
    aluop_i = 3'd7; exe_i = 1; rfwen_i = 1; modify_i = 1;
    #2;
    n_vec++; if (result_o !== 16'h0000 || ex_stall_o !== 1'b0 || rfwen_o !== 1'b1) begin
      n_err++; $display("FAIL mul_off: got %h stall %b rfwen %b expected 0000/0/1", result_o, ex_stall_o, rfwen_o); end
    @(posedge clk); #1;
    exp_flags = 4'b1000;
    n_vec++; if (flags_o !== exp_flags) begin n_err++; $display("FAIL mul_off_flags: got %b expected %b", flags_o, exp_flags); end
    clear_inputs();
  endtask
`endif

  task automatic test_random();
    logic [19:0] exp;
    logic [15:0] a, bf;
    logic        v;
    for (int i = 0; i < 300; i++) begin
      pc_i = 16'($urandom); waddr_i = 4'($urandom); wdatasc1_i = 2'($urandom); wdatasc2_i = 1'($urandom);
      rdata1_i = 16'($urandom); rdata2_i = 16'($urandom);
      raddr1_i = 4'($urandom_range(0, 3)); raddr2_i = 4'($urandom_range(0, 3));
      exmem_rfwen_i = 1'($urandom); exmem_waddr_i = 4'($urandom_range(0, 3)); exmem_data_i = 16'($urandom);
      memwb_rfwen_i = 1'($urandom); memwb_waddr_i = 4'($urandom_range(0, 3)); memwb_data_i = 16'($urandom);
      aluop_i = 3'($urandom_range(0, MAXOP)); imm_i = 4'($urandom); immed_i = 8'($urandom);
      bsc_i = 1'($urandom); immedsc_i = 1'($urandom); modify_i = 1'($urandom);
      rfwen_i = 1'($urandom); dmwen_i = 1'($urandom);
      exe_i = ($urandom_range(0, 9) != 0); postflush_i = ($urandom_range(0, 9) == 0);
      poststall_i = ($urandom_range(0, 9) == 0); ex_kill_i = ($urandom_range(0, 9) == 0);
      a   = model_fwd(raddr1_i, rdata1_i);
      bf  = model_fwd(raddr2_i, rdata2_i);
      exp = ref_exec(aluop_i, a, model_opb(), imm_i);
      v   = exe_i && !postflush_i && !poststall_i && !ex_kill_i;
      #2;
      n_vec++; if (result_o !== exp[15:0] || store_data_o !== bf) begin
        n_err++; $display("FAIL rnd_data vec %0d op %0d: got %h/%h expected %h/%h", i, aluop_i, result_o, store_data_o, exp[15:0], bf); end
      n_vec++; if (rfwen_o !== (rfwen_i && v) || dmwen_o !== (dmwen_i && v) || ex_stall_o !== 1'b0) begin
        n_err++; $display("FAIL rnd_ctrl vec %0d: got rf %b dm %b stall %b expected %b/%b/0", i, rfwen_o, dmwen_o, ex_stall_o, rfwen_i && v, dmwen_i && v); end
      n_vec++; if (pc_o !== pc_i || waddr_o !== waddr_i || wdatasc1_o !== wdatasc1_i || wdatasc2_o !== wdatasc2_i) begin
        n_err++; $display("FAIL rnd_pass vec %0d: got pc %h wa %h expected %h/%h", i, pc_o, waddr_o, pc_i, waddr_i); end
      n_vec++; if (flags_o !== exp_flags) begin
        n_err++; $display("FAIL rnd_flags vec %0d: got %b expected %b", i, flags_o, exp_flags); end
      if (v && modify_i) exp_flags = exp[19:16];
      @(posedge clk); #1;
    end
    n_vec++; if (flags_o !== exp_flags) begin n_err++; $display("FAIL rnd_flags_final: got %b expected %b", flags_o, exp_flags); end
    clear_inputs();
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    exp_flags = 4'b0000;
    rst       = 1'b1;
    clear_inputs();
    test_reset();
    test_add_overflow();
    test_sub();
    test_forwarding();
    test_immediate();
`ifdef EX_MULDIV_EN
    test_mul_seq(16'h0012, 16'h0034);
    test_mul_abort(1'b0);
    test_mul_seq(16'hBEEF, 16'h1357);
    test_mul_abort(1'b1);
    test_mul_seq(16'hFFFF, 16'h8001);
`else
    test_mul_single();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 16-bit five-stage pipeline. It consumes the ID/EX pipeline-register outputs and resolves operand forwarding from EX/MEM and MEM/WB. It computes the ALU result, maintains the architectural flag register, and runs an optional iterative multiplier that stalls the front end. All outputs feed the EX/MEM register.

## Interface
- DATA_W, 16, datapath width; only 16 is supported.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- pc_i  in  16  PC of the instruction in EX; passed through to pc_o.
- rdata1_i, rdata2_i  in  16  register-file read data captured in ID.
- raddr1_i, raddr2_i  in  4  source register numbers.
- waddr_i  in  4  destination register.
- imm_i  in  4  short immediate, also the shift amount.
- immed_i  in  8  long immediate.
- aluop_i  in  3  operation select.
- bsc_i  in  1  B-operand select: 0 selects the register, 1 selects an immediate.
- immedsc_i  in  1  immediate select: 0 selects zero-extended imm_i, 1 selects sign-extended immed_i.
- modify_i  in  1  instruction updates flags.
- dmwen_i, rfwen_i, exe_i  in  1  memory write, register write, instruction-present.
- wdatasc1_i  in  2  writeback-select field; passed through.
- wdatasc2_i  in  1  writeback-select field; passed through.
- postflush_i, poststall_i  in  1  bubble markers from ID/EX.
- exmem_rfwen_i, exmem_waddr_i (4), exmem_data_i (16)  in  forwarding source 1, which has priority.
- memwb_rfwen_i, memwb_waddr_i (4), memwb_data_i (16)  in  forwarding source 2.
- ex_kill_i  in  1  redirect from a later stage; aborts the instruction in EX.
- result_o  out  16  ALU or multiplier result.
- store_data_o  out  16  forwarded B register value, never the immediate.
- waddr_o, pc_o, wdatasc1_o, wdatasc2_o  out  pass-through fields.
- rfwen_o, dmwen_o  out  1  write enables, gated by the valid signal.
- flags_o  out  4  flag register {Z,N,C,V}.
- ex_stall_o  out  1  freezes PC, IF/ID and ID/EX; EX/MEM captures a bubble.

## Operation
- valid = exe_i & ~postflush_i & ~poststall_i & ~ex_kill_i.
- rfwen_o and dmwen_o equal the corresponding input AND valid AND ~ex_stall_o.
- Forwarding, evaluated separately for A (raddr1_i) and B (raddr2_i):
  - if exmem_rfwen_i is high and exmem_waddr_i matches, use exmem_data_i;
  - else if memwb_rfwen_i is high and memwb_waddr_i matches, use memwb_data_i;
  - else use the register-file read data.
  - Every register number forwards; none is hardwired to zero.
- B operand: if bsc_i is 0, use the forwarded B value. If bsc_i is 1, use the immediate selected by immedsc_i.
- aluop_i encodings and results:
  - 000 ADD: A+B.
  - 001 SUB: A−B.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SHL: A<<imm_i.
  - 110 SHR: A>>imm_i, logical shift.
  - 111 MUL: low 16 bits of A×B.
- Flags, computed from the 16-bit result:
  - Z: result == 0.
  - N: result[15].
  - C: carry-out for ADD; borrow for SUB (set when A<B unsigned).
  - V: signed overflow for ADD and SUB.
  - C and V are 0 for all other operations.
- Flag register resets to 4'b0000. It loads only when valid & modify_i & ~ex_stall_o.
- Multiplier FSM states: IDLE, BUSY, DONE. A 5-bit counter and latched operands belong to the FSM.
  - IDLE → BUSY when valid and aluop_i is 111. Forwarded A and B are latched at that edge.
  - BUSY runs one shift-add iteration per cycle. It moves to DONE after 16 iterations.
  - DONE → IDLE unconditionally.
  - ex_kill_i in any state forces IDLE at the next edge and discards the partial product.
  - rst forces IDLE and clears the counter, including mid-operation.

## Timing
- Non-MUL instructions: result_o and the enables are combinational within the cycle they occupy EX. Flags update at that edge.
- MUL instruction entering EX in cycle 0:
  - ex_stall_o is high in cycles 0–16 (combinational in cycle 0, from the IDLE-start condition).
  - Cycles 1–16 are in BUSY. Cycle 17 is in DONE: result_o holds the product, ex_stall_o is 0, and rfwen_o is asserted. Flags load at the end of cycle 17.
  - The MUL occupies EX for 18 cycles.
  - DONE never restarts the same instruction.
- Reset values:
  - ex_stall_o = 0, flags_o = 0, FSM in IDLE.
  - Pass-through outputs follow their inputs. With ID/EX in reset they are all zero.

## Configuration
- EX_MULDIV_EN defined: the multiplier FSM is present and behaves as described above.
- EX_MULDIV_EN undefined:
  - aluop 111 yields 16'h0000 in a single cycle and sets Z=1 when modify_i is high.
  - ex_stall_o is tied to 0.
  - No FSM state is instantiated.

## Structure
- Shared package ex_pkg holds:
  - the ALUOP_* encodings;
  - the flag bit indices FLAG_Z, FLAG_N, FLAG_C and FLAG_V;
  - MUL_ITER = 16.
- The iterative multiplier is a natural sub-module, ex_mul_seq: start/kill in, busy/done/product out. It is instantiated only under EX_MULDIV_EN.

## Test plan
- ADD with rdata1=16'h7FFF, rdata2=16'h0001 and modify=1 → result 16'h8000, flags {Z,N,C,V}=0101.
- SUB with A=16'h0003, B=16'h0005 → result 16'hFFFE, C=1, N=1.
- Both forwarding sources matching raddr1: exmem_data=16'h1111, memwb_data=16'h2222 → A=16'h1111. Remove exmem_rfwen → A=16'h2222.
- bsc=1, immedsc=1, immed=8'hF0, ADD with A=16'h0010 → result 16'h0000 and Z=1.
- MUL with A=16'h0012, B=16'h0034 → ex_stall_o high for exactly 17 cycles, then result 16'h03A8 with rfwen_o=1 in cycle 17.
- MUL with ex_kill_i pulsed in cycle 5 → stall drops in cycle 6, no rfwen_o and flags unchanged. A rst pulse mid-BUSY behaves identically.
